// File: rtl/repl_write_ctrl_pkg.sv
// rtl/repl_write_ctrl_pkg.sv - shared constants and state encoding for the replicated-bank write controller
package repl_write_ctrl_pkg;

    localparam int BLOCKSIZE_DEF  = 10;
    localparam int ADDR_W         = BLOCKSIZE_DEF + 1;
    localparam int DEPTH          = 2 << BLOCKSIZE_DEF;
    localparam int DATA_W         = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Width of the packed {addr, data} word held in the request FIFO
    function automatic int fifo_width(input int block_size);
        return block_size + 1 + DATA_W;
    endfunction

endpackage

// File: rtl/repl_write_ctrl_if.sv
// rtl/repl_write_ctrl_if.sv - upstream write request and bank broadcast bundle
interface repl_write_ctrl_if #(
    parameter int AW = repl_write_ctrl_pkg::ADDR_W
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          en_w1;
    logic [AW-1:0] w1_addr;
    logic [31:0]   w1_din;
    logic          init_done;
    logic [31:0]   wr_count;

    // Upstream requester / observer of the bank write port
    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, en_w1, w1_addr, w1_din, init_done, wr_count
    );

    // Write controller side
    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, en_w1, w1_addr, w1_din, init_done, wr_count
    );
endinterface

// File: rtl/repl_wfifo.sv
// rtl/repl_wfifo.sv - small synchronous FIFO buffering write requests
module repl_wfifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occ;
    logic             push_ok;
    logic             pop_ok;

    // Overflow/underflow requests are ignored rather than corrupting state
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign empty     = (occ == '0);
    assign full      = (occ == (PW+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Storage array: no reset needed, occupancy qualifies every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/repl_write_ctrl.sv
// rtl/repl_write_ctrl.sv - clears replicated banks after reset, then broadcasts queued writes
module repl_write_ctrl
    import repl_write_ctrl_pkg::*;
#(
    parameter int BLOCKSIZE  = BLOCKSIZE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    repl_write_ctrl_if.slave bus
);
    localparam int AW     = BLOCKSIZE + 1;
    localparam int NWORDS = 2 << BLOCKSIZE;
    localparam int FW     = fifo_width(BLOCKSIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] clr_cnt_d;
    logic          en_q;
    logic          en_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [31:0]   din_q;
    logic [31:0]   din_d;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;
    logic          init_q;
    logic          init_d;
    logic          ready_en_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [FW-1:0] fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_ready_int;

    // ready_en_q holds wr_ready low through reset; otherwise ready tracks registered occupancy
    assign wr_ready_int = ready_en_q && !fifo_full;
    assign fifo_push    = bus.wr_valid && wr_ready_int;

    assign bus.wr_ready  = wr_ready_int;
    assign bus.en_w1     = en_q;
    assign bus.w1_addr   = addr_q;
    assign bus.w1_din    = din_q;
    assign bus.init_done = init_q;
    assign bus.wr_count  = cnt_q;

    repl_wfifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({bus.wr_addr, bus.wr_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Next state and next bank-port values; requests wait in the FIFO until the sweep ends
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        en_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        init_d    = init_q || (state_q == ST_RUN);
        case (state_q)
            ST_CLEAR: begin
                en_d   = 1'b1;
                addr_d = clr_cnt_q;
                din_d  = '0;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    en_d     = 1'b1;
                    addr_d   = fifo_head[FW-1:32];
                    din_d    = fifo_head[31:0];
                    fifo_pop = 1'b1;
                    cnt_d    = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bank port, sweep counter, commit counter and status
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q  <= '0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            init_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            clr_cnt_q  <= clr_cnt_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            init_q     <= init_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_repl_write_ctrl.sv
// tb/tb_repl_write_ctrl.sv - scoreboard bench for repl_write_ctrl
module tb_repl_write_ctrl;
    localparam int NW = 2048;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;

    repl_write_ctrl_if bus ();

    repl_write_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t         exp_q [$];
    logic [31:0] bank    [NW];
    logic [31:0] ref_mem [NW];
    int          n_checks = 0;
    int          n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endfunction

    // Monitor: every bank write must match the head of the expected queue
    always @(negedge clk) begin
        if (bus.en_w1 === 1'b1) begin
            bank[bus.w1_addr] = bus.w1_din;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.w1_addr, bus.w1_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("issue_addr", 64'(bus.w1_addr), 64'(e.addr));
                check("issue_data", 64'(bus.w1_din), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        tick();
        tick();
        exp_q.delete();
        check("rst_en_w1", 64'(bus.en_w1), 64'd0);
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("rst_init_done", 64'(bus.init_done), 64'd0);
        check("rst_wr_count", 64'(bus.wr_count), 64'd0);
        check("rst_w1_addr", 64'(bus.w1_addr), 64'd0);
        check("rst_w1_din", 64'(bus.w1_din), 64'd0);
        for (int i = 0; i < NW; i++) begin
            wr_t e;
            e.addr = 11'(i);
            e.data = 32'd0;
            exp_q.push_back(e);
            ref_mem[i] = 32'd0;
        end
        rst = 1'b0;
    endtask

    task automatic send(input logic [10:0] a, input logic [31:0] d, output int waited);
        wr_t e;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        waited = 0;
        while (bus.wr_ready !== 1'b1 && waited < 5000) begin
            tick();
            waited++;
        end
        if (waited >= 5000) fail_now("send_timeout");
        tick();
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        ref_mem[a] = d;
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.init_done !== 1'b1) && t < 10000) begin
            tick();
            t++;
        end
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic compare_banks(input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < NW; i++) begin
            if (bank[i] !== ref_mem[i]) errs++;
        end
        check(name, 64'(errs), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [10:0] a;
        logic [31:0] d;

        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset release with no requests: full 2048-word clear sweep
        do_reset();
        check("ready_before_edge", 64'(bus.wr_ready), 64'd0);
        tick();
        check("ready_after_rst", 64'(bus.wr_ready), 64'd1);
        check("sweep_first_en", 64'(bus.en_w1), 64'd1);
        check("sweep_first_addr", 64'(bus.w1_addr), 64'd0);
        repeat (2047) tick();
        check("sweep_last_addr", 64'(bus.w1_addr), 64'd2047);
        check("sweep_last_en", 64'(bus.en_w1), 64'd1);
        check("init_not_yet", 64'(bus.init_done), 64'd0);
        tick();
        check("init_done_rise", 64'(bus.init_done), 64'd1);
        check("run_idle_en", 64'(bus.en_w1), 64'd0);
        check("sweep_all_seen", 64'(exp_q.size()), 64'd0);
        compare_banks("banks_cleared");

        // Five requests during the sweep with a 4-deep FIFO
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(11'(100 + i), 32'hC0DE_0000 + 32'(i), w);
        end
        check("full_ready_low", 64'(bus.wr_ready), 64'd0);
        check("still_clearing", 64'(bus.init_done), 64'd0);
        send(11'd200, 32'hDEAD_0005, w);
        check("fifth_wait", 64'(w >= 2040 && w <= 2050), 64'd1);
        wait_drain();
        check("count_after_five", 64'(bus.wr_count), 64'd5);
        compare_banks("banks_five");

        // Single write in RUN: one idle cycle, then issued
        do_reset();
        wait_drain();
        send(11'd5, 32'h0000_00A5, w);
        check("lat_wait", 64'(w), 64'd0);
        check("lat_idle", 64'(bus.en_w1), 64'd0);
        tick();
        check("lat_en", 64'(bus.en_w1), 64'd1);
        check("lat_addr", 64'(bus.w1_addr), 64'd5);
        check("lat_din", 64'(bus.w1_din), 64'hA5);
        check("lat_count", 64'(bus.wr_count), 64'd1);

        // 100 back-to-back random writes
        for (int i = 0; i < 100; i++) begin
            wr_t e;
            a = 11'($urandom_range(2047, 0));
            d = $urandom;
            bus.wr_valid = 1'b1;
            bus.wr_addr  = a;
            bus.wr_data  = d;
            if (i > 1) check("b2b_en", 64'(bus.en_w1), 64'd1);
            check("b2b_ready", 64'(bus.wr_ready), 64'd1);
            tick();
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
            ref_mem[a] = d;
        end
        bus.wr_valid = 1'b0;
        check("b2b_tail_en", 64'(bus.en_w1), 64'd1);
        wait_drain();
        check("count_after_100", 64'(bus.wr_count), 64'd101);
        compare_banks("banks_random");

        // Two writes to the same address: later one wins
        send(11'd7, 32'h11, w);
        send(11'd7, 32'h22, w);
        wait_drain();
        check("addr7_last", 64'(bank[7]), 64'h22);
        check("count_after_dup", 64'(bus.wr_count), 64'd103);
        compare_banks("banks_dup");

        // Reset mid-sweep with three queued requests
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(11'(300 + i), 32'hBEEF_0000 + 32'(i), w);
        end
        w = 0;
        while (!(bus.en_w1 === 1'b1 && bus.w1_addr === 11'd1000) && w < 3000) begin
            tick();
            w++;
        end
        if (w >= 3000) fail_now("reach_addr_1000");
        check("mid_sweep_addr", 64'(bus.w1_addr), 64'd1000);
        do_reset();
        tick();
        check("restart_en", 64'(bus.en_w1), 64'd1);
        check("restart_addr", 64'(bus.w1_addr), 64'd0);
        wait_drain();
        repeat (4) tick();
        check("dropped_count", 64'(bus.wr_count), 64'd0);
        check("no_extra_writes", 64'(exp_q.size()), 64'd0);
        compare_banks("banks_after_restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
